pulse_meter: RTL and testbench



---
 rtl/pulse_meter_pkg.sv | 23 ++
 rtl/pulse_meter_sampler.sv | 58 +++++
 rtl/pulse_meter.sv | 131 +++++++++++++
 tb/tb_pulse_meter.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/pulse_meter_pkg.sv
// ============================================================================
// pulse_meter_pkg : shared state encoding and default width for pulse_meter
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package pulse_meter_pkg;

    localparam int PM_DEFAULT_WIDTH = 16;

    localparam logic [1:0] PM_IDLE = 2'd0;
    localparam logic [1:0] PM_HIGH = 2'd1;
    localparam logic [1:0] PM_LOW  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = PM_IDLE,
        S_HIGH = PM_HIGH,
        S_LOW  = PM_LOW
    } pm_state_t;

endpackage

`default_nettype wire

// File: rtl/pulse_meter_sampler.sv
// ============================================================================
// pulse_meter_sampler : samples the pulse input and emits registered rise/fall
// strobes. PULSE_METER_SYNC_EN selects a two-flop synchronizer front end.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module pulse_meter_sampler
    import pulse_meter_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic signal,
    output logic rise,
    output logic fall
);

    logic r_s;
    logic r_s_prev;

`ifdef PULSE_METER_SYNC_EN
    logic r_meta;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_meta <= 1'b0;
            r_s    <= 1'b0;
        end else begin
            r_meta <= signal;
            r_s    <= r_meta;
        end
    end
`else
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_s <= 1'b0;
        end else begin
            r_s <= signal;
        end
    end
`endif

    // Strobes are registered so the FSM sees clean single-cycle events.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_s_prev <= 1'b0;
            rise     <= 1'b0;
            fall     <= 1'b0;
        end else begin
            r_s_prev <= r_s;
            rise     <= r_s & ~r_s_prev;
            fall     <= ~r_s & r_s_prev;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pulse_meter.sv
// ============================================================================
// pulse_meter : measures high time and period of a pulse signal in clocks.
// Optional input synchronizer via PULSE_METER_SYNC_EN (see sampler).
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module pulse_meter
    import pulse_meter_pkg::*;
#(
    parameter int WIDTH = PM_DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             signal,
    output logic [WIDTH-1:0] high_time,
    output logic [WIDTH-1:0] period,
    output logic             valid,
    output logic             overflow
);

    localparam logic [WIDTH-1:0] c_CNT_MAX = '1;
    localparam logic [WIDTH-1:0] c_CNT_ONE = WIDTH'(1);

    pm_state_t        r_state;
    pm_state_t        w_next_state;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_hi_lat;
    logic             r_ovf;
    logic             r_en_q;

    logic             w_rise;
    logic             w_fall;
    logic             w_at_max;
    logic [WIDTH-1:0] w_cnt_next;
    logic [WIDTH-1:0] w_hi_lat_next;
    logic             w_ovf_next;
    logic             w_publish;

    pulse_meter_sampler u_sampler (
        .clock  (clock),
        .reset  (reset),
        .signal (signal),
        .rise   (w_rise),
        .fall   (w_fall)
    );

    assign w_at_max = (r_cnt == c_CNT_MAX);

    always_comb begin
        w_next_state  = r_state;
        w_cnt_next    = w_at_max ? r_cnt : (r_cnt + c_CNT_ONE);
        w_ovf_next    = r_ovf | w_at_max;
        w_hi_lat_next = r_hi_lat;
        w_publish     = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_cnt_next = '0;
                w_ovf_next = 1'b0;
                // A rise coinciding with the enable edge is skipped on purpose.
                if (r_en_q && w_rise) begin
                    w_next_state = S_HIGH;
                    w_cnt_next   = c_CNT_ONE;
                end
            end
            S_HIGH: begin
                if (w_fall) begin
                    w_hi_lat_next = r_cnt;
                    w_next_state  = S_LOW;
                end
            end
            S_LOW: begin
                if (w_rise) begin
                    w_publish    = 1'b1;
                    w_cnt_next   = c_CNT_ONE;
                    w_ovf_next   = 1'b0;
                    w_next_state = S_HIGH;
                end
            end
            default: begin
                w_next_state = S_IDLE;
                w_cnt_next   = '0;
                w_ovf_next   = 1'b0;
            end
        endcase

        if (!enable) begin
            w_next_state = S_IDLE;
            w_cnt_next   = '0;
            w_ovf_next   = 1'b0;
            w_publish    = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            r_hi_lat  <= '0;
            r_ovf     <= 1'b0;
            r_en_q    <= 1'b0;
            high_time <= '0;
            period    <= '0;
            overflow  <= 1'b0;
            valid     <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_next;
            r_hi_lat <= w_hi_lat_next;
            r_ovf    <= w_ovf_next;
            r_en_q   <= enable;
            valid    <= w_publish;
            if (w_publish) begin
                high_time <= r_hi_lat;
                period    <= r_cnt;
                overflow  <= r_ovf;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pulse_meter.sv
// ============================================================================
// tb_pulse_meter : directed scoreboard bench for pulse_meter (WIDTH 16 and 4)
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pulse_meter;

`ifdef PULSE_METER_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    typedef struct {
        int h;
        int l;
        int k;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        signal;
    logic [15:0] ht16, pe16;
    logic        v16, ov16;
    logic [3:0]  ht4, pe4;
    logic        v4, ov4;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t q[$];
    exp_t e;
    bit   exp_v;
    bit   armed  = 1'b0;
    int   prev_h = 0;
    int   prev_l = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pulse_meter #(.WIDTH(16)) dut (
        .clock(clk), .reset(rst), .enable(enable), .signal(signal),
        .high_time(ht16), .period(pe16), .valid(v16), .overflow(ov16)
    );

    pulse_meter #(.WIDTH(4)) dut4 (
        .clock(clk), .reset(rst), .enable(enable), .signal(signal),
        .high_time(ht4), .period(pe4), .valid(v4), .overflow(ov4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v, input int w);
        int m;
        m = (1 << w) - 1;
        return (v > m) ? m : v;
    endfunction

    function automatic int ovf(input int v, input int w);
        return (v > ((1 << w) - 1)) ? 1 : 0;
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Rising edge: closes the previous measured period, if one was armed.
    task automatic rise_now();
        if (armed) q.push_back('{h: prev_h, l: prev_l, k: cyc + 1});
        signal = 1'b1;
    endtask

    task automatic drive(input int h, input int l);
        rise_now();
        armed  = 1'b1;
        prev_h = h;
        prev_l = l;
        step(h);
        signal = 1'b0;
        step(l);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            exp_v = (q.size() > 0) && (cyc == q[0].k + LAT);
            check("valid_w16", 32'(v16), 32'(exp_v));
            check("valid_w4", 32'(v4), 32'(exp_v));
            if (exp_v) begin
                e = q.pop_front();
                check("high_time_w16", 32'(ht16), sat(e.h, 16));
                check("period_w16", 32'(pe16), sat(e.h + e.l, 16));
                check("overflow_w16", 32'(ov16), ovf(e.h + e.l, 16));
                check("high_time_w4", 32'(ht4), sat(e.h, 4));
                check("period_w4", 32'(pe4), sat(e.h + e.l, 4));
                check("overflow_w4", 32'(ov4), ovf(e.h + e.l, 4));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst    = 1'b1;
        enable = 1'b0;
        signal = 1'b0;
        step(2);
        check("rst_high_time", 32'(ht16), 0);
        check("rst_period", 32'(pe16), 0);
        check("rst_valid", 32'(v16), 0);
        check("rst_overflow", 32'(ov16), 0);
        rst    = 1'b0;
        enable = 1'b1;
        step(4);

        repeat (4) drive(4, 6);
        repeat (4) drive(1, 1);
        drive(3, 17);
        drive(2, 3);
        drive(4, 6);

        // Enable dropped mid-LOW: interrupted period never reported.
        rise_now();
        armed = 1'b0;
        step(4);
        signal = 1'b0;
        step(2);
        enable = 1'b0;
        step(3);
        check("hold_high_time", 32'(ht16), 4);
        check("hold_period", 32'(pe16), 10);
        check("hold_overflow", 32'(ov16), 0);
        step(2);
        enable = 1'b1;
        step(3);
        repeat (3) drive(4, 6);

        // Asynchronous reset in the middle of a HIGH phase.
        rise_now();
        step(5);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_high_time", 32'(ht16), 0);
        check("async_rst_period", 32'(pe16), 0);
        check("async_rst_valid", 32'(v16), 0);
        check("async_rst_period_w4", 32'(pe4), 0);
        check("queue_empty_at_reset", 32'(q.size()), 0);
        @(posedge clk);
        #1;
        signal = 1'b0;
        step(3);
        rst   = 1'b0;
        armed = 1'b0;
        step(3);
        check("post_rst_period", 32'(pe16), 0);
        repeat (3) drive(2, 2);
        step(10);
        check("all_reports_seen", 32'(q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
